// File: rtl/hc595_pkg.sv
// Shared types and helpers for the 74HC595 chain driver.
package hc595_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LATCH
    } state_e;

    localparam int PWM_W = 4;

    // Counter width that never collapses to zero bits.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

endpackage

// File: rtl/hc595_bit_timer.sv
// Half-period divider for the shift clock: owns div_cnt and the shcp phase,
// and strobes the end of each half-period and of each full bit.
module hc595_bit_timer
    import hc595_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_run,
    input  logic i_shift,
    output logic o_phase,
    output logic o_phase_end,
    output logic o_bit_end
);

    localparam int DIV_W = clog2_min1(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_phase;

    assign o_phase     = r_phase;
    assign o_phase_end = (r_div_cnt == DIV_LAST);
    assign o_bit_end   = o_phase_end && r_phase;

    // Phase only toggles while shifting so LATCH leaves shcp low.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (i_clr) begin
            r_div_cnt <= '0;
            r_phase   <= 1'b0;
        end else if (i_run) begin
            r_div_cnt <= o_phase_end ? '0 : r_div_cnt + DIV_W'(1);
            if (i_shift && o_phase_end) begin
                r_phase <= ~r_phase;
            end
        end
    end

endmodule

// File: rtl/hc595_chain_driver.sv
// Serial driver for a cascade of N_CHIPS 74HC595s with valid/ready input.
// Optional macro HC595_PWM_DIM_EN adds a brightness input driving PWM on oe.
module hc595_chain_driver
    import hc595_pkg::*;
#(
    parameter int N_CHIPS   = 2,
    parameter int CLK_DIV   = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                   sys_clk,
    input  logic                   sys_rst,
`ifdef HC595_PWM_DIM_EN
    input  logic [PWM_W-1:0]       brightness,
`endif
    input  logic [8*N_CHIPS-1:0]   data_in,
    input  logic                   data_valid,
    output logic                   data_ready,
    output logic                   ds,
    output logic                   shcp,
    output logic                   stcp,
    output logic                   oe
);

    localparam int W     = 8 * N_CHIPS;
    localparam int BIT_W = clog2_min1(W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(W - 1);

    state_e           r_state, w_state_d;
    logic [W-1:0]     r_shift, w_shift_d, w_shifted;
    logic [BIT_W-1:0] r_bit_cnt, w_bit_cnt_d;
    logic             r_ds, w_ds_d;
    logic             r_stcp, r_ready, r_oe, w_oe_d;
    logic             r_latched, w_latched_d;
    logic             w_accept, w_last_bit;
    logic             w_phase, w_phase_end, w_bit_end;

    assign w_accept   = (r_state == IDLE) && data_valid && r_ready;
    assign w_last_bit = (r_bit_cnt == BIT_LAST);
    assign w_shifted  = MSB_FIRST ? {r_shift[W-2:0], 1'b0} : {1'b0, r_shift[W-1:1]};

    hc595_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .i_clk       (sys_clk),
        .i_rst       (sys_rst),
        .i_clr       (w_accept),
        .i_run       (r_state != IDLE),
        .i_shift     (r_state == SHIFT),
        .o_phase     (w_phase),
        .o_phase_end (w_phase_end),
        .o_bit_end   (w_bit_end)
    );

    always_comb begin
        w_state_d   = r_state;
        w_shift_d   = r_shift;
        w_bit_cnt_d = r_bit_cnt;
        w_ds_d      = r_ds;
        w_latched_d = r_latched;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_d   = SHIFT;
                    w_shift_d   = data_in;
                    w_bit_cnt_d = '0;
                    w_ds_d      = MSB_FIRST ? data_in[W-1] : data_in[0];
                end
            end
            SHIFT: begin
                if (w_bit_end) begin
                    if (w_last_bit) begin
                        // ds keeps the final bit through LATCH.
                        w_state_d = LATCH;
                    end else begin
                        w_bit_cnt_d = r_bit_cnt + BIT_W'(1);
                        w_shift_d   = w_shifted;
                        w_ds_d      = MSB_FIRST ? w_shifted[W-1] : w_shifted[0];
                    end
                end
            end
            LATCH: begin
                if (w_phase_end) begin
                    w_state_d   = IDLE;
                    w_latched_d = 1'b1;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

`ifdef HC595_PWM_DIM_EN
    logic [PWM_W-1:0] r_pwm_cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_pwm_cnt <= '0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
        end
    end

    always_comb begin
        w_oe_d = ~(w_latched_d && (r_pwm_cnt < brightness));
    end
`else
    always_comb begin
        w_oe_d = ~w_latched_d;
    end
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state   <= IDLE;
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_ds      <= 1'b0;
            r_stcp    <= 1'b0;
            r_ready   <= 1'b0;
            r_latched <= 1'b0;
            r_oe      <= 1'b1;
        end else begin
            r_state   <= w_state_d;
            r_shift   <= w_shift_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_ds      <= w_ds_d;
            r_stcp    <= (w_state_d == LATCH);
            r_ready   <= (w_state_d == IDLE);
            r_latched <= w_latched_d;
            r_oe      <= w_oe_d;
        end
    end

    assign data_ready = r_ready;
    assign ds         = r_ds;
    assign shcp       = w_phase;
    assign stcp       = r_stcp;
    assign oe         = r_oe;

endmodule
